chacha_poly1305_block_feeder: RTL and testbench

//  Upstream stage of the Poly1305 adapter. Packs a 32-bit word stream (AAD segment, then payload segment) into
//  128-bit, zero-padded, little-endian blocks on the adapter's aad_*/pld_* ports, then builds the RFC 8439

---
 rtl/chacha_poly1305_block_feeder_if.sv | 38 +++
 rtl/chacha_poly1305_block_feeder.sv | 225 ++++++++++++++++++++++
 tb/tb_chacha_poly1305_block_feeder.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/chacha_poly1305_block_feeder_if.sv
// Bundles the feeder's handshake buses: the 32-bit input word stream and the
// three 128-bit block outputs (AAD, payload, length) toward the Poly1305 adapter.
// The feeder uses the master modport: it drives s_ready and all block outputs.
// Whatever sits around it (word source plus adapter) uses the slave modport.
interface chacha_poly1305_block_feeder_if;
  // input word stream
  logic         s_valid;
  logic [31:0]  s_data;
  logic [3:0]   s_keep;
  logic         s_last;
  logic         s_ready;
  // AAD blocks
  logic         aad_valid;
  logic [127:0] aad_data;
  logic [15:0]  aad_keep;
  logic         aad_ready;
  // payload blocks
  logic         pld_valid;
  logic [127:0] pld_data;
  logic [15:0]  pld_keep;
  logic         pld_ready;
  // length block
  logic         len_valid;
  logic [127:0] len_block;
  logic         len_ready;

  modport master (
    input  s_valid, s_data, s_keep, s_last, aad_ready, pld_ready, len_ready,
    output s_ready, aad_valid, aad_data, aad_keep, pld_valid, pld_data, pld_keep,
           len_valid, len_block
  );

  modport slave (
    output s_valid, s_data, s_keep, s_last, aad_ready, pld_ready, len_ready,
    input  s_ready, aad_valid, aad_data, aad_keep, pld_valid, pld_data, pld_keep,
           len_valid, len_block
  );
endinterface

// File: rtl/chacha_poly1305_block_feeder.sv
// Poly1305 block feeder: packs a 32-bit little-endian word stream (AAD segment,
// then payload segment) into zero-padded 128-bit blocks, then emits the
// length block {payload bytes, AAD bytes}. Byte counters wrap at 2^LEN_W.
// Optional build macro CHAPOLY_FEED_ERR_EN: malformed keep beats are dropped
// and the feeder parks in ERR with a sticky err flag until the next start.
module chacha_poly1305_block_feeder #(
  parameter int LEN_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  chacha_poly1305_block_feeder_if.master bus,
  output logic [LEN_W-1:0] aad_len_bytes,
  output logic [LEN_W-1:0] pld_len_bytes,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    AAD_COL  = 3'd1,
    AAD_EMIT = 3'd2,
    PLD_COL  = 3'd3,
    PLD_EMIT = 3'd4,
    LEN_EMIT = 3'd5,
    DONE     = 3'd6
`ifdef CHAPOLY_FEED_ERR_EN
    , ERR    = 3'd7
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [127:0]      buf_q, buf_d;
  logic [15:0]       keep_q, keep_d;
  logic [1:0]        slot_q, slot_d;
  logic [LEN_W-1:0]  aad_cnt_q, aad_cnt_d;
  logic [LEN_W-1:0]  pld_cnt_q, pld_cnt_d;
  logic              last_q, last_d;     // block being collected closes its segment
  logic              done_q, done_d;
`ifdef CHAPOLY_FEED_ERR_EN
  logic              err_q, err_d;
  logic              beat_bad;
`endif

  logic              in_col;
  logic [2:0]        last_len;           // contiguous low ones of s_keep
  logic [2:0]        beat_len;           // bytes this beat contributes
  logic [3:0]        lane_en;
  logic [31:0]       word_masked;

  assign in_col = (state_q == AAD_COL) || (state_q == PLD_COL);

  // Byte count of a final beat: number of contiguous 1s from keep bit 0.
  always_comb begin
    if (!bus.s_keep[0])      last_len = 3'd0;
    else if (!bus.s_keep[1]) last_len = 3'd1;
    else if (!bus.s_keep[2]) last_len = 3'd2;
    else if (!bus.s_keep[3]) last_len = 3'd3;
    else                     last_len = 3'd4;
  end

  // Non-final beats always carry a full word.
  assign beat_len = bus.s_last ? last_len : 3'd4;

`ifdef CHAPOLY_FEED_ERR_EN
  // Malformed beat: short non-final beat, or holes in the keep mask.
  assign beat_bad = (!bus.s_last && (bus.s_keep != 4'hF)) ||
                    !((bus.s_keep == 4'h0) || (bus.s_keep == 4'h1) || (bus.s_keep == 4'h3) ||
                      (bus.s_keep == 4'h7) || (bus.s_keep == 4'hF));
`endif

  // Per-lane enable and zeroing of bytes beyond the valid count.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_en[gi]            = (beat_len > 3'(gi));
      assign word_masked[8*gi +: 8] = lane_en[gi] ? bus.s_data[8*gi +: 8] : 8'h00;
    end
  endgenerate

  // Next-state and datapath update; every target gets its hold value first.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    keep_d    = keep_q;
    slot_d    = slot_q;
    aad_cnt_d = aad_cnt_q;
    pld_cnt_d = pld_cnt_q;
    last_d    = last_q;
    done_d    = 1'b0;
`ifdef CHAPOLY_FEED_ERR_EN
    err_d     = err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = AAD_COL;
          buf_d     = '0;
          keep_d    = '0;
          slot_d    = '0;
          aad_cnt_d = '0;
          pld_cnt_d = '0;
          last_d    = 1'b0;
        end
      end
      AAD_COL, PLD_COL: begin
        if (bus.s_valid) begin
`ifdef CHAPOLY_FEED_ERR_EN
          if (beat_bad) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
`else
          begin
`endif
            if (bus.s_last && (beat_len == 3'd0) && (slot_q == 2'd0)) begin
              // empty tail with nothing buffered: no block for this segment end
              state_d = (state_q == AAD_COL) ? PLD_COL : LEN_EMIT;
            end else begin
              buf_d[{slot_q, 5'd0} +: 32] = word_masked;
              keep_d[{slot_q, 2'd0} +: 4] = lane_en;
              slot_d = slot_q + 2'd1;
              if (state_q == AAD_COL) aad_cnt_d = aad_cnt_q + LEN_W'(beat_len);
              else                    pld_cnt_d = pld_cnt_q + LEN_W'(beat_len);
              if ((slot_q == 2'd3) || bus.s_last) begin
                last_d  = bus.s_last;
                state_d = (state_q == AAD_COL) ? AAD_EMIT : PLD_EMIT;
              end
            end
          end
        end
      end
      AAD_EMIT: begin
        if (bus.aad_ready) begin
          buf_d   = '0;
          keep_d  = '0;
          slot_d  = '0;
          last_d  = 1'b0;
          state_d = last_q ? PLD_COL : AAD_COL;
        end
      end
      PLD_EMIT: begin
        if (bus.pld_ready) begin
          buf_d   = '0;
          keep_d  = '0;
          slot_d  = '0;
          last_d  = 1'b0;
          state_d = last_q ? LEN_EMIT : PLD_COL;
        end
      end
      LEN_EMIT: begin
        if (bus.len_ready) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
`ifdef CHAPOLY_FEED_ERR_EN
      ERR: begin
        if (start) begin
          state_d   = AAD_COL;
          err_d     = 1'b0;
          buf_d     = '0;
          keep_d    = '0;
          slot_d    = '0;
          aad_cnt_d = '0;
          pld_cnt_d = '0;
          last_d    = 1'b0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any message in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      keep_q    <= '0;
      slot_q    <= '0;
      aad_cnt_q <= '0;
      pld_cnt_q <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CHAPOLY_FEED_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      keep_q    <= keep_d;
      slot_q    <= slot_d;
      aad_cnt_q <= aad_cnt_d;
      pld_cnt_q <= pld_cnt_d;
      last_q    <= last_d;
      done_q    <= done_d;
`ifdef CHAPOLY_FEED_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  // Outputs are decoded from registered state only; data is zero unless offered.
  assign bus.s_ready   = in_col;
  assign bus.aad_valid = (state_q == AAD_EMIT);
  assign bus.aad_data  = bus.aad_valid ? buf_q  : '0;
  assign bus.aad_keep  = bus.aad_valid ? keep_q : '0;
  assign bus.pld_valid = (state_q == PLD_EMIT);
  assign bus.pld_data  = bus.pld_valid ? buf_q  : '0;
  assign bus.pld_keep  = bus.pld_valid ? keep_q : '0;
  assign bus.len_valid = (state_q == LEN_EMIT);
  assign bus.len_block = {64'(pld_cnt_q), 64'(aad_cnt_q)};

  assign aad_len_bytes = aad_cnt_q;
  assign pld_len_bytes = pld_cnt_q;
  assign busy          = (state_q != IDLE) && (state_q != DONE);
  assign done          = done_q;
`ifdef CHAPOLY_FEED_ERR_EN
  assign err           = err_q;
`else
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_chacha_poly1305_block_feeder.sv
// Randomised bench for chacha_poly1305_block_feeder. Messages are modelled as
// byte arrays; expected blocks are the 16-byte chunks of each segment, zero
// padded, and the expected length block is built from the segment sizes.
module tb_chacha_poly1305_block_feeder;
  localparam int LEN_W = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] aad_len_bytes, pld_len_bytes;
  logic             busy, done, err;

  chacha_poly1305_block_feeder_if bus_if();

  chacha_poly1305_block_feeder #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus_if),
    .aad_len_bytes(aad_len_bytes), .pld_len_bytes(pld_len_bytes),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct { logic [31:0] d; logic [3:0] k; logic l; } beat_t;
  typedef struct { logic [127:0] d; logic [15:0] k; } blk_t;

  beat_t beats[$];
  blk_t  exp_aad[$];
  blk_t  exp_pld[$];
  bit    aborted_flag;

  // Random segment of n bytes -> stream beats plus expected 16-byte blocks.
  task automatic build_segment(input int n, input bit is_aad);
    logic [7:0] b[$];
    beat_t t;
    blk_t  blk;
    for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    if (n == 0) begin
      t.d = $urandom; t.k = 4'h0; t.l = 1'b1;
      beats.push_back(t);
    end
    for (int i = 0; i < n; i += 4) begin
      int rem;
      rem = (n - i < 4) ? n - i : 4;
      t.d = $urandom;                       // unused lanes carry garbage
      for (int j = 0; j < rem; j++) t.d[8*j +: 8] = b[i+j];
      t.k = 4'((1 << rem) - 1);
      t.l = (i + 4 >= n);
      beats.push_back(t);
    end
    for (int s = 0; s < n; s += 16) begin
      blk.d = '0; blk.k = '0;
      for (int j = 0; j < 16 && s + j < n; j++) begin
        blk.d[8*j +: 8] = b[s+j];
        blk.k[j] = 1'b1;
      end
      if (is_aad) exp_aad.push_back(blk); else exp_pld.push_back(blk);
    end
  endtask

  task automatic drive_idle();
    bus_if.s_valid = 1'b0; bus_if.s_data = '0; bus_if.s_keep = '0; bus_if.s_last = 1'b0;
    bus_if.aad_ready = 1'b0; bus_if.pld_ready = 1'b0; bus_if.len_ready = 1'b0;
    start = 1'b0;
  endtask

  // One complete message: start, stream beats, consume and compare blocks.
  task automatic run_msg(input int alen, input int plen, input bit hold10,
                         input bit start_mid, input bit bad_keep, input bit abort_pld);
    int bi, cyc, tail, done_cnt, viol, hold, n_aad_beats, prev_sel;
    bit mid_done;
    logic [127:0] prev_d;
    logic [15:0]  prev_k;
    blk_t e;
    beats.delete(); exp_aad.delete(); exp_pld.delete();
    build_segment(alen, 1'b1);
    n_aad_beats = beats.size();
    if (bad_keep && beats.size() > 1 && !beats[0].l) beats[0].k = 4'h7;
    build_segment(plen, 1'b0);

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_eq("start_aad_cnt", aad_len_bytes, 0);
    check_eq("start_pld_cnt", pld_len_bytes, 0);
    check_eq("start_busy", busy, 1);

    bi = 0; cyc = 0; tail = -1; done_cnt = 0; viol = 0; hold = 0;
    prev_sel = 0; prev_d = '0; prev_k = '0; mid_done = 1'b0;
    while (cyc < 4000 && tail != 0) begin
      cyc++;
      if (tail > 0) tail--;
      if (done) done_cnt++;
      // a block offered last cycle without ready must still be offered unchanged
      if (prev_sel == 1 && !(bus_if.aad_valid && bus_if.aad_data == prev_d && bus_if.aad_keep == prev_k)) viol++;
      if (prev_sel == 2 && !(bus_if.pld_valid && bus_if.pld_data == prev_d && bus_if.pld_keep == prev_k)) viol++;
      if (prev_sel == 3 && !(bus_if.len_valid && bus_if.len_block == prev_d)) viol++;
      if (int'(bus_if.aad_valid) + int'(bus_if.pld_valid) + int'(bus_if.len_valid) > 1) viol++;
      if ((bus_if.aad_valid || bus_if.pld_valid || bus_if.len_valid) && bus_if.s_ready) viol++;
      if (abort_pld && bus_if.pld_valid) begin
        aborted_flag = 1'b1;
        drive_idle();
        return;
      end

      bus_if.aad_ready = ($urandom_range(0, 3) != 0);
      bus_if.len_ready = ($urandom_range(0, 3) != 0);
      if (hold10 && bus_if.pld_valid && hold < 10) begin
        bus_if.pld_ready = 1'b0;
        hold++;
      end else begin
        bus_if.pld_ready = hold10 ? 1'b1 : ($urandom_range(0, 3) != 0);
      end

      prev_sel = 0;
      if (bus_if.aad_valid) begin
        if (bus_if.aad_ready) begin
          if (exp_aad.size() == 0) check_eq("aad_extra_block", 1, 0);
          else begin
            e = exp_aad.pop_front();
            check_eq("aad_data", bus_if.aad_data, e.d);
            check_eq("aad_keep", bus_if.aad_keep, e.k);
          end
        end else begin
          prev_sel = 1; prev_d = bus_if.aad_data; prev_k = bus_if.aad_keep;
        end
      end
      if (bus_if.pld_valid) begin
        if (bus_if.pld_ready) begin
          if (exp_pld.size() == 0) check_eq("pld_extra_block", 1, 0);
          else begin
            e = exp_pld.pop_front();
            check_eq("pld_data", bus_if.pld_data, e.d);
            check_eq("pld_keep", bus_if.pld_keep, e.k);
          end
        end else begin
          prev_sel = 2; prev_d = bus_if.pld_data; prev_k = bus_if.pld_keep;
        end
      end
      if (bus_if.len_valid) begin
        if (bus_if.len_ready) begin
          check_eq("len_block", bus_if.len_block, {64'(plen), 64'(alen)});
          tail = 4;
        end else begin
          prev_sel = 3; prev_d = bus_if.len_block; prev_k = '0;
        end
      end

      start = 1'b0;
      if (start_mid && !mid_done && bi == n_aad_beats && bus_if.s_ready) begin
        start = 1'b1;
        mid_done = 1'b1;
      end

      if (bi < beats.size() && $urandom_range(0, 3) != 0) begin
        bus_if.s_valid = 1'b1;
        bus_if.s_data  = beats[bi].d;
        bus_if.s_keep  = beats[bi].k;
        bus_if.s_last  = beats[bi].l;
      end else begin
        bus_if.s_valid = 1'b0;
        bus_if.s_data  = $urandom;
        bus_if.s_keep  = 4'($urandom);
        bus_if.s_last  = 1'($urandom);
      end
      if (bus_if.s_valid && bus_if.s_ready) bi++;
      @(negedge clk);
    end
    drive_idle();
    if (tail != 0) check_eq("timeout", 1, 0);
    if (start_mid) check_eq("start_mid_issued", mid_done, 1);
    check_eq("done_pulses", done_cnt, 1);
    check_eq("aad_blocks_left", exp_aad.size(), 0);
    check_eq("pld_blocks_left", exp_pld.size(), 0);
    check_eq("aad_len_bytes", aad_len_bytes, alen);
    check_eq("pld_len_bytes", pld_len_bytes, plen);
    check_eq("busy_after_done", busy, 0);
    check_eq("protocol", viol, 0);
    $display("msg aad=%0d pld=%0d hold=%0d start_mid=%0d cycles=%0d", alen, plen, hold10, start_mid, cyc);
  endtask

  initial begin
    drive_idle();
    aborted_flag = 1'b0;
    repeat (3) @(negedge clk);
    // in reset
    check_eq("rst_busy", busy, 0);
    check_eq("rst_s_ready", bus_if.s_ready, 0);
    check_eq("rst_valids", {bus_if.aad_valid, bus_if.pld_valid, bus_if.len_valid}, 0);
    check_eq("rst_len_block", bus_if.len_block, 0);
    check_eq("rst_counts", {aad_len_bytes, pld_len_bytes}, 0);
    check_eq("rst_done_err", {done, err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_s_ready", bus_if.s_ready, 0);
    check_eq("idle_data", {bus_if.aad_data, bus_if.pld_data}, 0);

    run_msg(12, 16, 1'b0, 1'b0, 1'b0, 1'b0);   // AAD 12 bytes, payload one full block
    run_msg(0, 5, 1'b0, 1'b0, 1'b0, 1'b0);     // empty AAD, short payload
    run_msg(0, 32, 1'b1, 1'b0, 1'b0, 1'b0);    // payload stalled 10 cycles
    run_msg(16, 10, 1'b0, 1'b1, 1'b0, 1'b0);   // start pulse while in payload collection
`ifndef CHAPOLY_FEED_ERR_EN
    run_msg(12, 8, 1'b0, 1'b0, 1'b1, 1'b0);    // non-last keep=7 counts as a full word
`endif

    // reset while a payload block is on offer
    run_msg(8, 20, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("abort_reached", aborted_flag, 1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_pld_valid", bus_if.pld_valid, 0);
    check_eq("abort_pld_data", bus_if.pld_data, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_counts", {aad_len_bytes, pld_len_bytes}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_msg(4, 4, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int m = 0; m < 25; m++) begin
      run_msg(int'($urandom_range(0, 70)), int'($urandom_range(0, 70)),
              1'($urandom_range(0, 4) == 0), 1'b0, 1'b0, 1'b0);
    end

`ifdef CHAPOLY_FEED_ERR_EN
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    bus_if.s_valid = 1'b1; bus_if.s_keep = 4'h7; bus_if.s_last = 1'b0; bus_if.s_data = $urandom;
    @(negedge clk);
    bus_if.s_valid = 1'b0;
    check_eq("err_set", err, 1);
    check_eq("err_s_ready", bus_if.s_ready, 0);
    check_eq("err_valids", {bus_if.aad_valid, bus_if.pld_valid, bus_if.len_valid}, 0);
    check_eq("err_count", aad_len_bytes, 0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_eq("err_cleared", err, 0);
    check_eq("err_restart_ready", bus_if.s_ready, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
